wb2uart_host: RTL and testbench

- Host-side tunnel: a Wishbone slave that turns each 8-bit read/write into the ASCII command stream understood by the remote UART-to-Wishbone bridge.
- Sits between a local Wishbone master (CPU or test sequencer) and a UART byte transmitter/receiver pair.
- Encodes address/data as hex nibbles and, for reads, decodes the two-character hex reply.
- Skips resending the address when the remote auto-incremented address already matches the request.

---
 rtl/wb2uart_host.sv | 221 ++++++++++++++++++++++
 tb/tb_wb2uart_host.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb2uart_host.sv
// Wishbone slave that tunnels 8-bit reads/writes to a remote UART bridge
// as ASCII hex commands, with optional next-address caching.
module wb2uart_host #(
    parameter int ADDR_CACHE = 1,
    parameter int TIMEOUT    = 1000000
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [23:0] i_wb_addr,
    input  logic [7:0]  i_wb_dat,
    output logic [7:0]  o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    input  logic        i_remote_reset,
    output logic [7:0]  uart_tx_dat,
    output logic        uart_tx_trigger,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_rx_dat,
    input  logic        uart_received_strobe
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, SEND_RST, SEND_A, SEND_ANIB, SEND_D,
        SEND_DNIB, SEND_CMD, WAIT_TX, RX_HI, RX_LO
    } state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [23:0]   addr_q, addr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hi_q, hi_d;
    logic          cache_vld_q, cache_vld_d;
    logic [23:0]   cache_addr_q, cache_addr_d;
    logic          pend_q, pend_d;
    logic          trig_q, trig_d;
    logic [7:0]    tx_dat_q, tx_dat_d;
    logic [7:0]    rdat_q, rdat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic          send_req;
    logic          fire;
    logic [7:0]    tx_byte;
    logic [23:0]   addr_sh;
    logic          hit;
    logic          rx_dig;
    logic          rx_hex;
    logic          rx_vld;
    logic [3:0]    rx_nib;

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign addr_sh = addr_q >> {idx_q, 2'b00};
    assign hit     = (ADDR_CACHE != 0) && cache_vld_q
                     && (i_wb_addr == cache_addr_q);
    assign rx_dig  = (uart_rx_dat >= 8'h30) && (uart_rx_dat <= 8'h39);
    assign rx_hex  = (uart_rx_dat >= 8'h41) && (uart_rx_dat <= 8'h46);
    assign rx_vld  = uart_received_strobe && (rx_dig || rx_hex);
    assign rx_nib  = rx_dig ? uart_rx_dat[3:0] : uart_rx_dat[3:0] + 4'd9;

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdat_q       <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            hi_q         <= '0;
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            pend_q       <= 1'b0;
            trig_q       <= 1'b0;
            tx_dat_q     <= '0;
            rdat_q       <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdat_q       <= wdat_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            pend_q       <= pend_d;
            trig_q       <= trig_d;
            tx_dat_q     <= tx_dat_d;
            rdat_q       <= rdat_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    // A byte leaves only on an idle transmitter and never back to back.
    always_comb begin
        send_req = 1'b0;
        tx_byte  = 8'h00;
        unique case (state_q)
            SEND_RST:  begin send_req = 1'b1; tx_byte = 8'h2E; end
            SEND_A:    begin send_req = 1'b1; tx_byte = 8'h61; end
            SEND_ANIB: begin send_req = 1'b1; tx_byte = hex_enc(addr_sh[3:0]); end
            SEND_D:    begin send_req = 1'b1; tx_byte = 8'h64; end
            SEND_DNIB: begin
                send_req = 1'b1;
                tx_byte  = hex_enc(idx_q[0] ? wdat_q[7:4] : wdat_q[3:0]);
            end
            SEND_CMD:  begin send_req = 1'b1; tx_byte = we_q ? 8'h77 : 8'h72; end
            default:   ;
        endcase
        fire     = send_req && !uart_tx_busy && !trig_q;
        trig_d   = fire;
        tx_dat_d = fire ? tx_byte : tx_dat_q;
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdat_d       = wdat_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        pend_d       = pend_q || i_remote_reset;
        rdat_d       = rdat_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_q || i_remote_reset) begin
                    state_d = SEND_RST;
                end else if (i_wb_cyc && i_wb_stb) begin
                    we_d   = i_wb_we;
                    addr_d = i_wb_addr;
                    wdat_d = i_wb_dat;
                    idx_d  = '0;
                    if (hit) state_d = i_wb_we ? SEND_D : SEND_CMD;
                    else     state_d = SEND_A;
                end
            end
            SEND_RST: if (fire) begin
                state_d     = IDLE;
                pend_d      = i_remote_reset;
                cache_vld_d = 1'b0;
            end
            SEND_A: if (fire) begin
                state_d = SEND_ANIB;
                idx_d   = '0;
            end
            SEND_ANIB: if (fire) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) begin
                    idx_d   = '0;
                    state_d = we_q ? SEND_D : SEND_CMD;
                end
            end
            SEND_D: if (fire) begin
                state_d = SEND_DNIB;
                idx_d   = '0;
            end
            SEND_DNIB: if (fire) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd1) state_d = SEND_CMD;
            end
            SEND_CMD: if (fire) begin
                state_d = we_q ? WAIT_TX : RX_HI;
                cnt_d   = '0;
            end
            WAIT_TX: if (!uart_tx_busy && !trig_q) begin
                state_d      = IDLE;
                ack_d        = i_wb_cyc;
                cache_vld_d  = 1'b1;
                cache_addr_d = addr_q + 24'd1;
            end
            RX_HI, RX_LO: begin
                if (rx_vld) begin
                    cnt_d = '0;
                    if (state_q == RX_HI) begin
                        hi_d    = rx_nib;
                        state_d = RX_LO;
                    end else begin
                        rdat_d       = {hi_q, rx_nib};
                        ack_d        = i_wb_cyc;
                        cache_vld_d  = 1'b1;
                        cache_addr_d = addr_q + 24'd1;
                        state_d      = IDLE;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    rdat_d      = 8'hFF;
                    err_d       = i_wb_cyc;
                    cache_vld_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_wb_dat        = rdat_q;
    assign o_wb_ack        = ack_q;
    assign o_wb_err        = err_q;
    assign uart_tx_dat     = tx_dat_d;
    assign uart_tx_trigger = fire;

endmodule

// File: tb/tb_wb2uart_host.sv
// Directed bench for wb2uart_host: one cached and one uncached instance,
// each with a simple busy-for-3-cycles transmitter model.
module tb_wb2uart_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        stb_nc = 1'b0;
    logic        we = 1'b0;
    logic [23:0] addr = '0;
    logic [7:0]  wdat = '0;
    logic        rrst = 1'b0;
    logic [7:0]  rx_dat = '0;
    logic        rx_stb = 1'b0;

    logic [7:0]  rdat, tx_dat, rdat_nc, tx_dat_nc;
    logic        ack, err, trig, busy;
    logic        ack_nc, err_nc, trig_nc, busy_nc;

    int busy_cnt = 0;
    int busy_cnt_nc = 0;
    int bad_trig = 0;
    logic [7:0] txq[$];
    logic [7:0] txq_nc[$];

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb2uart_host #(.ADDR_CACHE(1), .TIMEOUT(100)) dut (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_dat(wdat),
        .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_err(err),
        .i_remote_reset(rrst),
        .uart_tx_dat(tx_dat), .uart_tx_trigger(trig),
        .uart_tx_busy(busy),
        .uart_rx_dat(rx_dat), .uart_received_strobe(rx_stb)
    );

    wb2uart_host #(.ADDR_CACHE(0), .TIMEOUT(100)) dut_nc (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb_nc), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_dat(wdat),
        .o_wb_dat(rdat_nc), .o_wb_ack(ack_nc), .o_wb_err(err_nc),
        .i_remote_reset(1'b0),
        .uart_tx_dat(tx_dat_nc), .uart_tx_trigger(trig_nc),
        .uart_tx_busy(busy_nc),
        .uart_rx_dat(rx_dat), .uart_received_strobe(rx_stb)
    );

    assign busy    = busy_cnt != 0;
    assign busy_nc = busy_cnt_nc != 0;

    always @(posedge clk) begin
        if (trig) begin
            if (busy_cnt != 0) bad_trig++;
            txq.push_back(tx_dat);
            busy_cnt <= 3;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (trig_nc) begin
            if (busy_cnt_nc != 0) bad_trig++;
            txq_nc.push_back(tx_dat_nc);
            busy_cnt_nc <= 3;
        end else if (busy_cnt_nc != 0) begin
            busy_cnt_nc <= busy_cnt_nc - 1;
        end
    end

    function automatic string q2s(input bit nc);
        string s = "";
        if (nc) foreach (txq_nc[i]) s = $sformatf("%s%c", s, txq_nc[i]);
        else    foreach (txq[i])    s = $sformatf("%s%c", s, txq[i]);
        return s;
    endfunction

    task automatic do_start(input bit nc, input bit w,
                            input logic [23:0] a, input logic [7:0] d);
        @(negedge clk);
        if (nc) txq_nc.delete();
        else    txq.delete();
        we = w; addr = a; wdat = d; cyc = 1'b1;
        if (nc) stb_nc = 1'b1;
        else    stb = 1'b1;
    endtask

    task automatic wait_done(input bit nc, input int budget,
                             output int acks, output int errs,
                             output logic [7:0] rd);
        int n = 0;
        int tail = 0;
        bit seen = 0;
        acks = 0; errs = 0; rd = '0;
        while (n < budget && tail < 8) begin
            @(negedge clk);
            n++;
            if (nc ? ack_nc : ack) begin acks++; rd = nc ? rdat_nc : rdat; end
            if (nc ? err_nc : err) begin errs++; rd = nc ? rdat_nc : rdat; end
            if ((nc ? (ack_nc | err_nc) : (ack | err)) && !seen) begin
                seen = 1;
                cyc = 1'b0; stb = 1'b0; stb_nc = 1'b0;
            end
            if (seen) tail++;
        end
        cyc = 1'b0; stb = 1'b0; stb_nc = 1'b0;
        if (!seen) begin
            n_checks++;
            $display("FAIL completion_wait: no ack/err within %0d cycles", budget);
        end
    endtask

    task automatic wait_r(input bit nc);
        int n = 0;
        bit got = 0;
        while (n < 300 && !got) begin
            @(negedge clk);
            n++;
            if (nc) got = txq_nc.size() > 0 && txq_nc[$] == 8'h72;
            else    got = txq.size() > 0 && txq[$] == 8'h72;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL wait_r: no 'r' command sent within 300 cycles");
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_dat = b; rx_stb = 1'b1;
        @(posedge clk);
        #1 rx_stb = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else n_pass++;
        n_checks++;
        if (trig !== 1'b0) $display("FAIL reset_trig: got %b want 0", trig);
        else n_pass++;
        n_checks++;
        if (rdat !== 8'h00) $display("FAIL reset_rdat: got %h want 00", rdat);
        else n_pass++;
        n_checks++;
        if (tx_dat !== 8'h00) $display("FAIL reset_txdat: got %h want 00", tx_dat);
        else n_pass++;
    endtask

    task automatic test_write_miss;
        int a, e;
        logic [7:0] d;
        string s;
        do_start(0, 1, 24'h123456, 8'h5A);
        wait_done(0, 300, a, e, d);
        s = q2s(0);
        n_checks++;
        if (s != "a654321dA5w") $display("FAIL wr_stream: got %s want a654321dA5w", s);
        else n_pass++;
        n_checks++;
        if (a != 1) $display("FAIL wr_ack_count: got %0d want 1", a);
        else n_pass++;
        n_checks++;
        if (e != 0) $display("FAIL wr_err_count: got %0d want 0", e);
        else n_pass++;
    endtask

    task automatic test_read_hit;
        int a, e;
        logic [7:0] d;
        string s;
        do_start(0, 0, 24'h123457, 8'h00);
        wait_r(0);
        send_rx(8'h0D);
        send_rx(8'h0A);
        send_rx(8'h33);
        send_rx(8'h43);
        wait_done(0, 50, a, e, d);
        s = q2s(0);
        n_checks++;
        if (s != "r") $display("FAIL rd_hit_stream: got %s want r", s);
        else n_pass++;
        n_checks++;
        if (a != 1) $display("FAIL rd_hit_ack: got %0d want 1", a);
        else n_pass++;
        n_checks++;
        if (d !== 8'h3C) $display("FAIL rd_hit_data: got %h want 3c", d);
        else n_pass++;
    endtask

    task automatic test_wrap;
        int a, e;
        logic [7:0] d;
        string s;
        do_start(0, 0, 24'hFFFFFF, 8'h00);
        wait_r(0);
        send_rx(8'h30);
        send_rx(8'h30);
        wait_done(0, 50, a, e, d);
        s = q2s(0);
        n_checks++;
        if (s != "aFFFFFFr") $display("FAIL wrap_first_stream: got %s want aFFFFFFr", s);
        else n_pass++;
        n_checks++;
        if (d !== 8'h00 || a != 1) $display("FAIL wrap_first_data: got %h/%0d want 00/1", d, a);
        else n_pass++;
        do_start(0, 0, 24'h000000, 8'h00);
        wait_r(0);
        send_rx(8'h41);
        send_rx(8'h37);
        wait_done(0, 50, a, e, d);
        s = q2s(0);
        n_checks++;
        if (s != "r") $display("FAIL wrap_hit_stream: got %s want r", s);
        else n_pass++;
        n_checks++;
        if (d !== 8'hA7) $display("FAIL wrap_hit_data: got %h want a7", d);
        else n_pass++;
        do_start(1, 0, 24'hFFFFFF, 8'h00);
        wait_r(1);
        send_rx(8'h30);
        send_rx(8'h30);
        wait_done(1, 50, a, e, d);
        do_start(1, 0, 24'h000000, 8'h00);
        wait_r(1);
        send_rx(8'h35);
        send_rx(8'h42);
        wait_done(1, 50, a, e, d);
        s = q2s(1);
        n_checks++;
        if (s != "a000000r") $display("FAIL nocache_stream: got %s want a000000r", s);
        else n_pass++;
        n_checks++;
        if (d !== 8'h5B || a != 1) $display("FAIL nocache_data: got %h/%0d want 5b/1", d, a);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int a, e;
        logic [7:0] d;
        string s;
        do_start(0, 0, 24'h000001, 8'h00);
        wait_r(0);
        wait_done(0, 300, a, e, d);
        s = q2s(0);
        n_checks++;
        if (s != "r") $display("FAIL to_stream: got %s want r", s);
        else n_pass++;
        n_checks++;
        if (e != 1 || a != 0) $display("FAIL to_pulses: got err=%0d ack=%0d want 1/0", e, a);
        else n_pass++;
        n_checks++;
        if (d !== 8'hFF) $display("FAIL to_data: got %h want ff", d);
        else n_pass++;
        do_start(0, 1, 24'h000001, 8'h3F);
        wait_done(0, 300, a, e, d);
        s = q2s(0);
        n_checks++;
        if (s != "a100000dF3w") $display("FAIL to_resend: got %s want a100000dF3w", s);
        else n_pass++;
    endtask

    task automatic test_remote_reset;
        int a, e;
        logic [7:0] d;
        string s;
        do_start(0, 1, 24'h000002, 8'hC4);
        repeat (2) @(negedge clk);
        rrst = 1'b1;
        @(negedge clk);
        rrst = 1'b0;
        wait_done(0, 300, a, e, d);
        repeat (10) @(negedge clk);
        s = q2s(0);
        n_checks++;
        if (s != "d4Cw.") $display("FAIL rrst_stream: got %s want d4Cw.", s);
        else n_pass++;
        n_checks++;
        if (a != 1) $display("FAIL rrst_ack: got %0d want 1", a);
        else n_pass++;
        do_start(0, 1, 24'h000003, 8'h00);
        wait_done(0, 300, a, e, d);
        s = q2s(0);
        n_checks++;
        if (s != "a300000d00w") $display("FAIL rrst_resend: got %s want a300000d00w", s);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        int n = 0;
        int sz;
        int a = 0;
        do_start(0, 1, 24'h000050, 8'h11);
        while (n < 100 && txq.size() < 3) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sz = txq.size();
        n_checks++;
        if (sz < 3 || sz > 7) $display("FAIL mid_rst_progress: got %0d bytes want 3..7", sz);
        else n_pass++;
        n_checks++;
        if ({trig, ack, err} !== 3'b000 || rdat !== 8'h00 || tx_dat !== 8'h00)
            $display("FAIL mid_rst_outputs: got trig=%b ack=%b err=%b rdat=%h txd=%h want all 0",
                     trig, ack, err, rdat, tx_dat);
        else n_pass++;
        repeat (20) begin
            @(negedge clk);
            if (ack || err) a++;
        end
        n_checks++;
        if (txq.size() != sz || a != 0)
            $display("FAIL mid_rst_quiet: got %0d bytes %0d acks want %0d bytes 0 acks",
                     txq.size(), a, sz);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_miss();
        test_read_hit();
        test_wrap();
        test_timeout();
        test_remote_reset();
        test_mid_reset();
        n_checks++;
        if (bad_trig != 0) $display("FAIL tx_protocol: got %0d triggers while busy want 0", bad_trig);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
